// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: initiator side of the shared 8-bit tri-state register bus.
// Moves one byte per request from a source latch (or an immediate driven by
// this block) into a destination latch using one-hot read/write strobes.
// Every transfer takes a fixed IDLE->READ->WRITE->DONE walk. All outputs,
// including the bus drive enable, come straight from flops.

module bus_xfer_ctrl #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic                clk50M_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic [IDX_W-1:0]    src_i,
    input  logic [IDX_W-1:0]    dst_i,
    input  logic                imm_sel_i,
    input  logic [7:0]          imm_i,
    output logic [NUM_REGS-1:0] latch_rd_o,
    output logic [NUM_REGS-1:0] latch_wr_o,
    inout  wire  [7:0]          bus_io,
    output logic [7:0]          data_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // An index is usable only if a latch actually exists at that position.
    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return (32'(idx) < 32'(NUM_REGS));
    endfunction

    // One-hot strobe for a latch index; out-of-range indices give no strobe.
    function automatic logic [NUM_REGS-1:0] strobe(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] s;
        if (idx_ok(idx)) begin
            s = NUM_REGS'(1) << idx;
        end else begin
            s = '0;
        end
        return s;
    endfunction

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    src_q, src_d;
    logic [IDX_W-1:0]    dst_q, dst_d;
    logic                imm_sel_q, imm_sel_d;
    logic [7:0]          imm_q, imm_d;
    logic [NUM_REGS-1:0] rd_q, rd_d;
    logic [NUM_REGS-1:0] wr_q, wr_d;
    logic                drv_q, drv_d;
    logic [7:0]          data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // Next-state and next-output decode; outputs are computed one cycle early
    // so that every strobe and the bus enable leave the block from a flop.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        imm_sel_d = imm_sel_q;
        imm_d     = imm_q;
        rd_d      = '0;
        wr_d      = '0;
        drv_d     = 1'b0;
        data_d    = data_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d   = ST_READ;
                    src_d     = src_i;
                    dst_d     = dst_i;
                    imm_sel_d = imm_sel_i;
                    imm_d     = imm_i;
                    busy_d    = 1'b1;
                    drv_d     = imm_sel_i;
                    if (imm_sel_i) begin
                        rd_d = '0;
                    end else begin
                        rd_d = strobe(src_i);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                // Source drive is held while the destination captures.
                state_d = ST_WRITE;
                busy_d  = 1'b1;
                drv_d   = imm_sel_q;
                wr_d    = strobe(dst_q);
                if (imm_sel_q) begin
                    rd_d = '0;
                end else begin
                    rd_d = strobe(src_q);
                end
            end
            ST_WRITE: begin
                // Snoop the byte the destination is capturing on this edge.
                state_d = ST_DONE;
                busy_d  = 1'b1;
                done_d  = 1'b1;
                data_d  = bus_io;
                err_d   = (!imm_sel_q && !idx_ok(src_q)) || !idx_ok(dst_q);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, captured request and registered outputs; reset drops strobes at once.
    always_ff @(posedge clk50M_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            imm_sel_q <= 1'b0;
            imm_q     <= 8'h00;
            rd_q      <= '0;
            wr_q      <= '0;
            drv_q     <= 1'b0;
            data_q    <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            imm_sel_q <= imm_sel_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            drv_q     <= drv_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus_io     = drv_q ? imm_q : 8'hzz;
    assign latch_rd_o = rd_q;
    assign latch_wr_o = wr_q;
    assign data_o     = data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: a behavioural 8-latch array on a pulled-up bus,
// a table of directed transfers, hand sequences for held request, reset in
// WRITE and out-of-range indices, then a random run against a latch model.
// A released bus reads 8'hFF through the pull-ups.

module tb_bus_xfer_ctrl;

    logic       clk;
    logic       rst;
    logic       req;
    logic [2:0] src, dst;
    logic       sel;
    logic [7:0] imm;
    logic [7:0] rd, wr, data;
    logic       busy, done, err;
    wire  [7:0] bus;

    logic       req6;
    logic [2:0] src6, dst6;
    logic       sel6;
    logic [7:0] imm6;
    logic [5:0] rd6, wr6;
    logic [7:0] data6;
    logic       busy6, done6, err6;
    wire  [7:0] bus6;

    logic [7:0] lat [8] = '{default: 8'h00};
    logic [7:0] mdl [8];
    logic [2:0] rd_idx;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         mon_viol = 0;

    bus_xfer_ctrl #(.NUM_REGS(8), .IDX_W(3)) u_dut (
        .clk50M_i(clk), .rst_i(rst), .req_i(req), .src_i(src), .dst_i(dst),
        .imm_sel_i(sel), .imm_i(imm), .latch_rd_o(rd), .latch_wr_o(wr),
        .bus_io(bus), .data_o(data), .busy_o(busy), .done_o(done), .err_o(err));

    bus_xfer_ctrl #(.NUM_REGS(6), .IDX_W(3)) u_dut6 (
        .clk50M_i(clk), .rst_i(rst), .req_i(req6), .src_i(src6), .dst_i(dst6),
        .imm_sel_i(sel6), .imm_i(imm6), .latch_rd_o(rd6), .latch_wr_o(wr6),
        .bus_io(bus6), .data_o(data6), .busy_o(busy6), .done_o(done6), .err_o(err6));

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (bus[g]);
        pullup (bus6[g]);
    end

    always #5 clk = ~clk;

    // Latch array read side: the addressed latch drives the bus.
    always_comb begin
        rd_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (rd[i]) rd_idx = 3'(i);
        end
    end
    assign bus = (rd != 8'h00) ? lat[rd_idx] : 8'hzz;

    // Latch array write side: strobed latches capture the bus.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (wr[i]) lat[i] <= bus;
        end
    end

    // Contention watch on every cycle of the whole run.
    always @(negedge clk) begin
        if (!$onehot0(rd) || !$onehot0(wr) || !$onehot0(rd6) || !$onehot0(wr6)) begin
            mon_viol <= mon_viol + 1;
        end
        if (rd != 8'h00 && bus !== lat[rd_idx]) begin
            mon_viol <= mon_viol + 1;
        end
    end

    typedef struct {
        logic       sel;
        logic [7:0] imm;
        logic [2:0] src;
        logic [2:0] dst;
        logic [7:0] e_rd;
        logic [7:0] e_wr;
        logic [7:0] e_data;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full transfer on the 8-latch instance with per-cycle checks.
    task automatic run_xfer(input logic s, input logic [7:0] im, input logic [2:0] sr,
                            input logic [2:0] ds, input logic [7:0] e_rd,
                            input logic [7:0] e_wr, input logic [7:0] e_data);
        @(negedge clk);
        sel = s; imm = im; src = sr; dst = ds; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("rd_in_read", rd, e_rd);
        chk("wr_in_read", wr, 8'h00);
        chk("bus_in_read", bus, e_data);
        chk("busy_in_read", busy, 1'b1);
        @(negedge clk);
        chk("rd_in_write", rd, e_rd);
        chk("wr_in_write", wr, e_wr);
        chk("bus_in_write", bus, e_data);
        chk("done_in_write", done, 1'b0);
        @(negedge clk);
        chk("done_in_done", done, 1'b1);
        chk("err_in_done", err, 1'b0);
        chk("data_in_done", data, e_data);
        chk("strobes_in_done", {rd, wr}, 16'h0000);
        chk("busy_in_done", busy, 1'b1);
        @(negedge clk);
        chk("done_after", done, 1'b0);
        chk("busy_after", busy, 1'b0);
        chk("bus_released", bus, 8'hFF);
        chk("latch_dst", lat[ds], e_data);
        mdl[ds] = e_data;
    endtask

    int         done_at [$];
    int         wr_seen;
    int         dn;
    logic       r_sel;
    logic [7:0] r_imm, r_data;
    logic [2:0] r_src, r_dst;

    initial begin
        tbl[0] = '{1'b1, 8'hA5, 3'd0, 3'd2, 8'h00, 8'h04, 8'hA5};
        tbl[1] = '{1'b1, 8'h3C, 3'd0, 3'd1, 8'h00, 8'h02, 8'h3C};
        tbl[2] = '{1'b0, 8'h00, 3'd1, 3'd6, 8'h02, 8'h40, 8'h3C};
        tbl[3] = '{1'b1, 8'h5A, 3'd0, 3'd0, 8'h00, 8'h01, 8'h5A};
        tbl[4] = '{1'b0, 8'h00, 3'd0, 3'd7, 8'h01, 8'h80, 8'h5A};
        tbl[5] = '{1'b0, 8'h00, 3'd2, 3'd2, 8'h04, 8'h04, 8'hA5};
        tbl[6] = '{1'b1, 8'hC3, 3'd0, 3'd5, 8'h00, 8'h20, 8'hC3};
        tbl[7] = '{1'b0, 8'h00, 3'd5, 3'd3, 8'h20, 8'h08, 8'hC3};
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;

        clk = 1'b0; rst = 1'b1; req = 1'b0; src = 3'd0; dst = 3'd0; sel = 1'b0; imm = 8'h00;
        req6 = 1'b0; src6 = 3'd0; dst6 = 3'd0; sel6 = 1'b0; imm6 = 8'h00;

        // Reset state
        #12;
        chk("rst_strobes", {rd, wr}, 16'h0000);
        chk("rst_flags", {busy, done, err}, 3'b000);
        chk("rst_data", data, 8'h00);
        chk("rst_bus", bus, 8'hFF);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_xfer(tbl[i].sel, tbl[i].imm, tbl[i].src, tbl[i].dst,
                     tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_data);
        end

        // Held request for 8 cycles: two transfers, done 4 cycles apart
        @(negedge clk);
        sel = 1'b0; src = 3'd0; dst = 3'd1; req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 8) req = 1'b0;
            if (done) done_at.push_back(c);
        end
        chk("held_req_count", done_at.size(), 2);
        if (done_at.size() == 2) begin
            chk("held_req_gap", done_at[1] - done_at[0], 4);
            chk("held_req_first", done_at[0], 3);
        end
        chk("held_req_latch", lat[1], 8'h5A);
        mdl[1] = 8'h5A;

        // Reset asserted during WRITE of an immediate load
        @(negedge clk);
        sel = 1'b1; imm = 8'h66; dst = 3'd3; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("rstw_wr_before", wr, 8'h08);
        chk("rstw_bus_before", bus, 8'h66);
        #1 rst = 1'b1;
        #1;
        chk("rstw_strobes", {rd, wr}, 16'h0000);
        chk("rstw_bus", bus, 8'hFF);
        chk("rstw_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("rstw_no_done", dn, 0);
        chk("rstw_dst_kept", lat[3], 8'hC3);

        // Six-latch instance: bad destination, then bad source
        @(negedge clk);
        sel6 = 1'b1; imm6 = 8'h77; dst6 = 3'd7; req6 = 1'b1;
        wr_seen = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            req6 = 1'b0;
            if (wr6 != 6'h00 || rd6 != 6'h00) wr_seen++;
            if (c == 3) chk("bad_dst_done_err", {done6, err6}, 2'b11);
            if (c == 2) chk("bad_dst_imm_bus", bus6, 8'h77);
        end
        chk("bad_dst_no_strobe", wr_seen, 0);
        @(negedge clk);
        sel6 = 1'b0; src6 = 3'd6; dst6 = 3'd0; req6 = 1'b1;
        wr_seen = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            req6 = 1'b0;
            if (rd6 != 6'h00) wr_seen++;
            if (c == 2) chk("bad_src_wr", wr6, 6'h01);
            if (c == 3) chk("bad_src_done_err", {done6, err6}, 2'b11);
            if (c == 4) chk("bad_src_idle", {busy6, done6, err6}, 3'b000);
        end
        chk("bad_src_no_rd", wr_seen, 0);

        // Random transfers against the latch model
        for (int n = 0; n < 1000; n++) begin
            r_sel = 1'($urandom_range(0, 1));
            r_imm = 8'($urandom);
            r_src = 3'($urandom_range(0, 7));
            r_dst = 3'($urandom_range(0, 7));
            r_data = r_sel ? r_imm : mdl[r_src];
            run_xfer(r_sel, r_imm, r_src, r_dst,
                     r_sel ? 8'h00 : (8'h01 << r_src), 8'h01 << r_dst, r_data);
        end

        @(negedge clk);
        chk("bus_monitor", mon_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
